// File: rtl/in_dev_pkg.sv
// Shared types and defaults for the input-device port.
package in_dev_pkg;

  localparam int unsigned DefDepth = 8;
  localparam int unsigned DefWidth = 8;

  // Four-phase handshake towards the processor.
  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StPresent = 2'b01,
    StRelease = 2'b10
  } hs_state_e;

endpackage

// File: rtl/byte_fifo.sv
// Circular byte buffer with occupancy count and full/empty/ready flags.
// Storage is not reset; only pointers and count are cleared.
module byte_fifo
  import in_dev_pkg::*;
#(
  parameter int unsigned DEPTH = DefDepth,
  parameter int unsigned WIDTH = DefWidth
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_valid_i,
  input  logic [WIDTH-1:0]         push_data_i,
  output logic                     push_ready_o,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o,
  output logic                     full_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             push, pop;

  assign full_o       = (count_q == CntW'(DEPTH));
  assign empty_o      = (count_q == '0);
  assign push_ready_o = ~full_o;
  assign push         = push_valid_i & push_ready_o;
  // Never pop an empty buffer, even if the caller misbehaves.
  assign pop          = pop_i & ~empty_o;
  assign rd_data_o    = mem_q[rd_ptr_q];
  assign count_o      = count_q;

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage write; a push during the clear cycle is dropped.
  always_ff @(posedge clk_i) begin
    if (rst_ni && push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/in_dev_port.sv
// Input-device port: buffers source bytes and hands them to the processor
// over a four-phase in_dev_hs / in_dev_ack handshake.
module in_dev_port
  import in_dev_pkg::*;
#(
  parameter int unsigned DEPTH = DefDepth,
  parameter int unsigned WIDTH = DefWidth
) (
  input  logic                   g_clk,
  input  logic                   g_clr,
  input  logic                   src_valid,
  input  logic [WIDTH-1:0]       src_data,
  output logic                   src_ready,
  output logic                   in_dev_hs,
  output logic [WIDTH-1:0]       input_bus,
  input  logic                   in_dev_ack,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   fifo_empty,
  output logic                   fifo_full
);

  hs_state_e        state_q, state_d;
  logic             hs_q;
  logic [WIDTH-1:0] bus_q;
  logic             load, pop;
  logic [WIDTH-1:0] fifo_rd_data;

  byte_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_fifo (
    .clk_i        (g_clk),
    .rst_ni       (g_clr),
    .push_valid_i (src_valid),
    .push_data_i  (src_data),
    .push_ready_o (src_ready),
    .pop_i        (pop),
    .rd_data_o    (fifo_rd_data),
    .count_o      (fifo_count),
    .empty_o      (fifo_empty),
    .full_o       (fifo_full)
  );

  // Next-state and strobes for the handshake; ack in IDLE blocks a new transfer.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty && !in_dev_ack) begin
          state_d = StPresent;
          load    = 1'b1;
        end
      end
      StPresent: begin
        if (in_dev_ack) begin
          state_d = StRelease;
          pop     = 1'b1;
        end
      end
      StRelease: begin
        if (!in_dev_ack) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State register; hs gets its own flop so the interrupt line never sees decode glitches.
  always_ff @(posedge g_clk) begin
    if (!g_clr) begin
      state_q <= StIdle;
      hs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hs_q    <= (state_d == StPresent);
    end
  end

  // Presented byte: loaded on IDLE->PRESENT, held afterwards.
  always_ff @(posedge g_clk) begin
    if (!g_clr) begin
      bus_q <= '0;
    end else if (load) begin
      bus_q <= fifo_rd_data;
    end
  end

  assign in_dev_hs = hs_q;
  assign input_bus = bus_q;

endmodule

// File: tb/tb_in_dev_port.sv
// Scoreboard bench for in_dev_port with a queue-based reference model.
module tb_in_dev_port;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned WIDTH = 8;

  logic             g_clk;
  logic             g_clr;
  logic             src_valid;
  logic [WIDTH-1:0] src_data;
  logic             src_ready;
  logic             in_dev_hs;
  logic [WIDTH-1:0] input_bus;
  logic             in_dev_ack;
  logic [3:0]       fifo_count;
  logic             fifo_empty;
  logic             fifo_full;

  in_dev_port #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) dut (
    .g_clk      (g_clk),
    .g_clr      (g_clr),
    .src_valid  (src_valid),
    .src_data   (src_data),
    .src_ready  (src_ready),
    .in_dev_hs  (in_dev_hs),
    .input_bus  (input_bus),
    .in_dev_ack (in_dev_ack),
    .fifo_count (fifo_count),
    .fifo_empty (fifo_empty),
    .fifo_full  (fifo_full)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  logic [WIDTH-1:0] mq[$];    // bytes held in the buffer (presented one included until popped)
  logic [WIDTH-1:0] sb_q[$];  // expected presentation order
  bit               m_hs, m_rel, model_live, hs_prev;
  logic [WIDTH-1:0] m_bus;
  bit               m_push, m_pop;
  int               m_sz;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Model: applies the port's rules to the inputs seen at each rising edge.
  initial forever begin
    @(posedge g_clk);
    if (!g_clr) begin
      mq.delete();
      sb_q.delete();
      m_hs       = 1'b0;
      m_rel      = 1'b0;
      m_bus      = '0;
      model_live = 1'b1;
    end else if (model_live) begin
      m_sz   = mq.size();
      m_push = src_valid && (m_sz != DEPTH);
      m_pop  = m_hs && in_dev_ack;
      if (m_hs) begin
        if (in_dev_ack) begin
          m_hs  = 1'b0;
          m_rel = 1'b1;
        end
      end else if (m_rel) begin
        if (!in_dev_ack) m_rel = 1'b0;
      end else if (m_sz != 0 && !in_dev_ack) begin
        m_hs  = 1'b1;
        m_bus = mq[0];
      end
      if (m_pop) void'(mq.pop_front());
      if (m_push) begin
        mq.push_back(src_data);
        sb_q.push_back(src_data);
      end
    end
  end

  // Monitor: compares outputs on the falling edge; each new presentation pops the scoreboard.
  initial forever begin
    @(negedge g_clk);
    if (model_live) begin
      check("hs", in_dev_hs, m_hs);
      check("bus", input_bus, m_bus);
      check("count", fifo_count, mq.size());
      check("empty", fifo_empty, mq.size() == 0);
      check("full", fifo_full, mq.size() == DEPTH);
      check("ready", src_ready, mq.size() != DEPTH);
      if (in_dev_hs && !hs_prev) begin
        if (sb_q.size() == 0) begin
          timeout_fail("present_unexpected");
        end else begin
          check("present_order", input_bus, sb_q.pop_front());
        end
      end
      hs_prev = in_dev_hs;
    end
  end

  task automatic do_reset(input int cycles);
    g_clr = 1'b0;
    repeat (cycles) @(negedge g_clk);
    g_clr = 1'b1;
  endtask

  task automatic wait_hs(input bit lvl, input string name);
    for (int i = 0; i < 64; i++) begin
      if (in_dev_hs === lvl) return;
      @(negedge g_clk);
    end
    timeout_fail(name);
  endtask

  task automatic send(input logic [WIDTH-1:0] d);
    bit r;
    src_valid = 1'b1;
    src_data  = d;
    for (int i = 0; i < 400; i++) begin
      r = src_ready;
      @(negedge g_clk);
      if (r) begin
        src_valid = 1'b0;
        return;
      end
    end
    src_valid = 1'b0;
    timeout_fail("send");
  endtask

  task automatic take_one();
    wait_hs(1'b1, "wait_present");
    in_dev_ack = 1'b1;
    @(negedge g_clk);
    wait_hs(1'b0, "wait_release");
    in_dev_ack = 1'b0;
    @(negedge g_clk);
  endtask

  initial begin
    g_clr      = 1'b0;
    src_valid  = 1'b0;
    src_data   = '0;
    in_dev_ack = 1'b0;
    @(negedge g_clk);

    // Reset then idle.
    do_reset(2);
    check("rst_hs", in_dev_hs, 0);
    check("rst_bus", input_bus, 8'h00);
    check("rst_empty", fifo_empty, 1);
    check("rst_ready", src_ready, 1);
    check("rst_count", fifo_count, 0);

    // Single byte: presented one edge after the push edge.
    send(8'hA5);
    @(negedge g_clk);
    check("single_hs", in_dev_hs, 1);
    check("single_bus", input_bus, 8'hA5);
    in_dev_ack = 1'b1;
    @(negedge g_clk);
    check("single_ack_hs", in_dev_hs, 0);
    check("single_ack_count", fifo_count, 0);
    in_dev_ack = 1'b0;
    repeat (2) @(negedge g_clk);

    // Fill to full with no acks, then try a ninth byte.
    for (int i = 1; i <= 8; i++) send(WIDTH'(i));
    check("fill_full", fifo_full, 1);
    check("fill_ready", src_ready, 0);
    src_valid = 1'b1;
    src_data  = 8'h09;
    repeat (3) @(negedge g_clk);
    src_valid = 1'b0;
    check("fill_ninth_count", fifo_count, 8);
    for (int i = 0; i < 8; i++) take_one();
    check("drain_empty", fifo_empty, 1);

    // Streaming with concurrent pops across pointer wrap.
    fork
      for (int i = 0; i < 20; i++) send(WIDTH'(8'h10 + i));
      for (int i = 0; i < 20; i++) take_one();
    join
    check("stream_sb_empty", sb_q.size(), 0);

    // Stuck ack from reset.
    in_dev_ack = 1'b1;
    do_reset(1);
    send(8'h5A);
    repeat (4) @(negedge g_clk);
    check("stuck_hs", in_dev_hs, 0);
    in_dev_ack = 1'b0;
    @(negedge g_clk);
    check("stuck_release_hs", in_dev_hs, 1);
    check("stuck_release_bus", input_bus, 8'h5A);
    take_one();

    // Reset in the middle of a transfer with bytes queued.
    for (int i = 0; i < 4; i++) send(WIDTH'(8'hC0 + i));
    wait_hs(1'b1, "mid_present");
    do_reset(1);
    check("mid_rst_hs", in_dev_hs, 0);
    check("mid_rst_count", fifo_count, 0);
    check("mid_rst_bus", input_bus, 0);
    send(8'h77);
    @(negedge g_clk);
    check("mid_next_bus", input_bus, 8'h77);
    take_one();

    // Randomized traffic, arbitrary ack behaviour and occasional clears.
    for (int i = 0; i < 600; i++) begin
      src_valid  = ($urandom_range(0, 2) != 0);
      src_data   = WIDTH'($urandom);
      in_dev_ack = ($urandom_range(0, 3) == 0) ? ~in_dev_ack : in_dev_ack;
      g_clr      = ($urandom_range(0, 99) != 0);
      @(negedge g_clk);
    end
    src_valid  = 1'b0;
    in_dev_ack = 1'b0;
    g_clr      = 1'b1;
    repeat (4) @(negedge g_clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
